// File: rtl/pet_control_fsm.sv
// Pet game control FSM: sequences renderer draw strobes and turns key presses into item pulses.
// Optional build macro ITEM_MATCH_FILTER_EN gates item pulses on the matching status flag.
module pet_control_fsm #(
  parameter logic [25:0] REFRESH_CYCLES = 26'd50_000_000,
  parameter logic [19:0] DRAW_TIMEOUT   = 20'd200_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start_key,
  input  logic       go_key,
  input  logic [4:0] item_sel,
  input  logic       hungry,
  input  logic       bored,
  input  logic       sick,
  input  logic       dirty,
  input  logic       dying,
  input  logic       deceased,
  input  logic       sleeping,
  input  logic       draw_done,
  output logic       draw_bg,
  output logic       draw_start,
  output logic       draw_end,
  output logic       draw_pet,
  output logic       draw_zs,
  output logic       draw_food,
  output logic       draw_ball,
  output logic       draw_broom,
  output logic       draw_pills,
  output logic       draw_firstAid,
  output logic       draw_hunger,
  output logic       draw_bored,
  output logic       draw_dirty,
  output logic       draw_sick,
  output logic       draw_dying,
  output logic       foodGiven,
  output logic       ballGiven,
  output logic       broomGiven,
  output logic       pillsGiven,
  output logic       firstAidGiven,
  output logic       draw_timeout_err
);

  typedef enum logic [3:0] {
    S_START, S_WAIT_START, S_BG, S_PET, S_STATUS,
    S_IDLE, S_OBJ, S_APPLY, S_END, S_END_WAIT
  } state_t;

  localparam int D_BG = 0, D_START = 1, D_END = 2, D_PET = 3, D_ZS = 4;
  localparam int D_FOOD = 5, D_BALL = 6, D_BROOM = 7, D_PILLS = 8, D_FAID = 9;
  localparam int D_HUNGER = 10, D_BORED = 11, D_DIRTY = 12, D_SICK = 13, D_DYING = 14;

  state_t      state;
  logic [14:0] strobe;
  logic [19:0] draw_timer;
  logic [25:0] refresh_timer;
  logic        start_prev, go_prev;
  logic [6:0]  flags_latched;
  logic [4:0]  item;
  logic [4:0]  given;
  logic        timeout_err;
`ifdef ITEM_MATCH_FILTER_EN
  logic        item_match;
`endif

  logic [6:0]  flags;
  logic        drawing, start_press, go_press, item_onehot, go_valid;
  logic [14:0] status_strobe, obj_strobe;

  assign flags       = {hungry, bored, sick, dirty, dying, deceased, sleeping};
  assign drawing     = |strobe;
  assign start_press = start_key & ~start_prev;
  assign go_press    = go_key & ~go_prev;
  assign item_onehot = (item_sel != 5'd0) && ((item_sel & (item_sel - 5'd1)) == 5'd0);
  assign go_valid    = go_press & item_onehot & ~sleeping & ~deceased;

  // Sleep overrides every bubble; otherwise the most urgent need is shown.
  always_comb begin
    status_strobe = '0;
    if (sleeping)    status_strobe[D_ZS]     = 1'b1;
    else if (dying)  status_strobe[D_DYING]  = 1'b1;
    else if (sick)   status_strobe[D_SICK]   = 1'b1;
    else if (hungry) status_strobe[D_HUNGER] = 1'b1;
    else if (dirty)  status_strobe[D_DIRTY]  = 1'b1;
    else if (bored)  status_strobe[D_BORED]  = 1'b1;
  end

  always_comb begin
    obj_strobe = '0;
    if (item[0])      obj_strobe[D_FOOD]  = 1'b1;
    else if (item[1]) obj_strobe[D_BALL]  = 1'b1;
    else if (item[2]) obj_strobe[D_PILLS] = 1'b1;
    else if (item[3]) obj_strobe[D_BROOM] = 1'b1;
    else if (item[4]) obj_strobe[D_FAID]  = 1'b1;
  end

  // Each draw state spends one cycle raising its strobe, then holds it until done or timeout.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= S_START;
      strobe        <= '0;
      draw_timer    <= '0;
      refresh_timer <= '0;
      start_prev    <= 1'b0;
      go_prev       <= 1'b0;
      flags_latched <= '0;
      item          <= '0;
      given         <= '0;
      timeout_err   <= 1'b0;
`ifdef ITEM_MATCH_FILTER_EN
      item_match    <= 1'b0;
`endif
    end else begin
      start_prev <= start_key;
      go_prev    <= go_key;
      given      <= '0;
      if (drawing) begin
        if (draw_done || draw_timer == DRAW_TIMEOUT) begin
          strobe     <= '0;
          draw_timer <= '0;
          if (!draw_done) timeout_err <= 1'b1;
          case (state)
            S_START:  state <= S_WAIT_START;
            S_BG:     state <= deceased ? S_END : S_PET;
            S_PET:    state <= deceased ? S_END : S_STATUS;
            S_STATUS: state <= deceased ? S_END : S_IDLE;
            S_OBJ: begin
              state <= S_APPLY;
`ifdef ITEM_MATCH_FILTER_EN
              given <= item_match ? item : 5'd0;
`else
              given <= item;
`endif
            end
            S_END:    state <= S_END_WAIT;
            default:  state <= S_START;
          endcase
        end else begin
          draw_timer <= draw_timer + 20'd1;
        end
      end else begin
        case (state)
          S_START:      strobe[D_START] <= 1'b1;
          S_WAIT_START: if (start_press) state <= S_BG;
          S_BG:         strobe[D_BG] <= 1'b1;
          S_PET:        strobe[D_PET] <= 1'b1;
          S_STATUS: begin
            flags_latched <= flags;
            if (status_strobe == 15'd0) state <= deceased ? S_END : S_IDLE;
            else                        strobe <= status_strobe;
          end
          S_IDLE: begin
            refresh_timer <= '0;
            if (deceased)                   state <= S_END;
            else if (flags != flags_latched) state <= S_BG;
            else if (go_valid) begin
              state <= S_OBJ;
              item  <= item_sel;
`ifdef ITEM_MATCH_FILTER_EN
              item_match <= |(item_sel & {dying, dirty, sick, bored, hungry});
`endif
            end
            else if (refresh_timer == REFRESH_CYCLES - 26'd1) state <= S_BG;
            else refresh_timer <= refresh_timer + 26'd1;
          end
          S_OBJ:        strobe <= obj_strobe;
          S_APPLY:      state <= deceased ? S_END : S_BG;
          S_END:        strobe[D_END] <= 1'b1;
          S_END_WAIT:   if (start_press) state <= S_START;
          default:      state <= S_START;
        endcase
      end
    end
  end

  assign draw_bg          = strobe[D_BG];
  assign draw_start       = strobe[D_START];
  assign draw_end         = strobe[D_END];
  assign draw_pet         = strobe[D_PET];
  assign draw_zs          = strobe[D_ZS];
  assign draw_food        = strobe[D_FOOD];
  assign draw_ball        = strobe[D_BALL];
  assign draw_broom       = strobe[D_BROOM];
  assign draw_pills       = strobe[D_PILLS];
  assign draw_firstAid    = strobe[D_FAID];
  assign draw_hunger      = strobe[D_HUNGER];
  assign draw_bored       = strobe[D_BORED];
  assign draw_dirty       = strobe[D_DIRTY];
  assign draw_sick        = strobe[D_SICK];
  assign draw_dying       = strobe[D_DYING];
  assign foodGiven        = given[0];
  assign ballGiven        = given[1];
  assign pillsGiven       = given[2];
  assign broomGiven       = given[3];
  assign firstAidGiven    = given[4];
  assign draw_timeout_err = timeout_err;

endmodule
